rename_reg_file: RTL
====================

// Module: rename_reg_file
// PURPOSE
//  Architectural register file with per-register rename tags. Commit side receives
//  ROB retirements (rob_to_reg_*). Decode side renames rd on issue and reads rs1/rs2
//  as value-or-tag. Sits between the ROB commit port and the decoder operand fetch.
//  ROB index 0 is never allocated, so tag 0 means "not renamed, value valid".
// PARAMETERS
//  REG_NUM     32  number of architectural registers (index width = log2(REG_NUM))
//  DATA_WIDTH  32  register value width
//  ROB_IDX_W   4   ROB index/tag width; tag 0 = no pending producer
// PORTS
//  clk_in                clk_in   1           clock, all state updates on posedge
//  rst_in                in   1           synchronous active-high reset
//  rdy_in                in   1           global enable; low = hold all state
//  clr_in                in   1           ROB mispredict flush
//  rob_to_reg_commit     in   1           commit valid
//  rob_to_reg_rob_index  in   ROB_IDX_W   ROB entry retiring
//  rob_to_reg_index      in   5           destination register of retiring entry
//  rob_to_reg_val        in   DATA_WIDTH  retiring result
//  dc_to_reg_rename      in   1           issue: rename rd this cycle
//  dc_to_reg_rd          in   5           register being renamed
//  dc_to_reg_rob_index   in   ROB_IDX_W   ROB entry allocated to rd
//  dc_to_reg_rs1         in   5           source 1 index
//  dc_to_reg_rs2         in   5           source 2 index
//  reg_to_dc_rs1_val     out  DATA_WIDTH  rs1 value (valid when tag==0)
//  reg_to_dc_rs1_tag     out  ROB_IDX_W   rs1 producer tag, 0 = ready
//  reg_to_dc_rs2_val     out  DATA_WIDTH  rs2 value
//  reg_to_dc_rs2_tag     out  ROB_IDX_W   rs2 producer tag
// BEHAVIOUR
//  - State: val[REG_NUM], tag[REG_NUM]. Reset (rst_in=1 at posedge): all val=0, all tag=0;
//    dominates clr_in and rdy_in. Outputs are combinational, no reset value of their own.
//  - rdy_in=0 (no reset): no state change; read outputs still driven.
//  - Commit (commit=1, rdy_in=1, index!=0): val[rd] <= commit_val. tag[rd] <= 0 only if
//    tag[rd]==rob_to_reg_rob_index (a newer rename is not disturbed).
//  - Rename (rename=1, rdy_in=1, clr_in=0, rd!=0): tag[rd] <= dc_to_reg_rob_index.
//  - Same rd committed and renamed in same cycle: rename tag wins; value still written.
//  - clr_in=1: all tags <= 0. A commit in the same cycle still writes its value (the
//    mispredicted branch retires with the flush). Rename in the same cycle is dropped.
//  - x0: writes, renames ignored; reads return val=0, tag=0 always.
//  - Read path (per source rsN, combinational, zero latency):
//      rsN==0                                  -> val 0, tag 0
//      commit && index==rsN && tag[rsN]==commit_rob_index -> val=commit_val, tag 0 (bypass)
//      else                                    -> val=val[rsN], tag=tag[rsN]
//    Reads see pre-rename state: same-cycle rename of rd==rsN does NOT affect rsN
//    (e.g. addi x1,x1,1 reads old x1 producer).
//  - Bypass applies only when rdy_in=1; with rdy_in=0 the stored state is returned.
//  - Tags are opaque; no arithmetic, no wrap handling here (ROB owns allocation).
// TESTING
//  1. Reset, read x5 -> val 0, tag 0; commit x5=0x1234 tag3 with tag[x5]=0 -> val 0x1234,
//     tag stays 0.
//  2. Rename x7->tag4; read x7 -> tag 4. Commit x7=0xAA idx4 -> same-cycle read val 0xAA,
//     tag 0; next cycle stored val 0xAA, tag 0.
//  3. Rename x7->4, rename x7->6, commit idx4 x7=0x11 -> val 0x11, tag stays 6.
//  4. Same cycle: commit x9 idx2 (tag[x9]=2) + rename x9->5, rs1=x9 -> rs1 bypass val,
//     tag 0 this cycle; next cycle tag 5.
//  5. Tags x1..x3 = 2,3,4; clr_in + commit x1 idx2 0xFF + rename x4->7 -> all tags 0,
//     x1=0xFF, x4 not renamed.
//  6. Write/rename x0 -> reads val 0, tag 0; rdy_in=0 with commit/rename -> no state change.

Source files
------------

// File: rtl/rename_reg_file_if.sv
// rename_reg_file_if
//   Groups the two client ports of the rename register file:
//   - ROB commit port: rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val
//   - Decoder port: dc_to_reg_rename, dc_to_reg_rd, dc_to_reg_rob_index, dc_to_reg_rs1/rs2,
//     and the returned reg_to_dc_rs1/rs2 value and tag.
//   Modports:
//   - master: the ROB/decoder side.
//   - slave: the register file.
interface rename_reg_file_if #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_IDX_W  = 4
);
  localparam int IDX_W = $clog2(REG_NUM);

  logic                  rob_to_reg_commit;
  logic [ROB_IDX_W-1:0]  rob_to_reg_rob_index;
  logic [IDX_W-1:0]      rob_to_reg_index;
  logic [DATA_WIDTH-1:0] rob_to_reg_val;

  logic                  dc_to_reg_rename;
  logic [IDX_W-1:0]      dc_to_reg_rd;
  logic [ROB_IDX_W-1:0]  dc_to_reg_rob_index;
  logic [IDX_W-1:0]      dc_to_reg_rs1;
  logic [IDX_W-1:0]      dc_to_reg_rs2;

  logic [DATA_WIDTH-1:0] reg_to_dc_rs1_val;
  logic [ROB_IDX_W-1:0]  reg_to_dc_rs1_tag;
  logic [DATA_WIDTH-1:0] reg_to_dc_rs2_val;
  logic [ROB_IDX_W-1:0]  reg_to_dc_rs2_tag;

  modport master (
    output rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
    output dc_to_reg_rename, dc_to_reg_rd, dc_to_reg_rob_index, dc_to_reg_rs1, dc_to_reg_rs2,
    input  reg_to_dc_rs1_val, reg_to_dc_rs1_tag, reg_to_dc_rs2_val, reg_to_dc_rs2_tag
  );

  modport slave (
    input  rob_to_reg_commit, rob_to_reg_rob_index, rob_to_reg_index, rob_to_reg_val,
    input  dc_to_reg_rename, dc_to_reg_rd, dc_to_reg_rob_index, dc_to_reg_rs1, dc_to_reg_rs2,
    output reg_to_dc_rs1_val, reg_to_dc_rs1_tag, reg_to_dc_rs2_val, reg_to_dc_rs2_tag
  );
endinterface

// File: rtl/rename_reg_file.sv
// rename_reg_file
//   Architectural register file in which every register carries a rename tag. The tag
//   is the ROB index of the pending producer. A tag of 0 means the stored value is
//   current, because ROB index 0 is never allocated.
//   Ports:
//   - clk_in: clock. All state updates on the rising edge.
//   - rst_in: synchronous active-high reset. Clears all values and tags.
//   - rdy_in: global enable. When low, state is held and reads still work.
//   - clr_in: mispredict flush. Clears all tags and drops a same-cycle rename.
//   - bus: the ROB commit port and the decoder rename/read port.
module rename_reg_file #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_IDX_W  = 4
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic clr_in,
  rename_reg_file_if.slave bus
);
  localparam int IDX_W = $clog2(REG_NUM);

  logic [DATA_WIDTH-1:0] val_q [REG_NUM];
  logic [DATA_WIDTH-1:0] val_d [REG_NUM];
  logic [ROB_IDX_W-1:0]  tag_q [REG_NUM];
  logic [ROB_IDX_W-1:0]  tag_d [REG_NUM];

  logic commit_en;
  logic rename_en;

  // Commit to x0 is discarded.
  // Rename is dropped during a flush, and a rename of x0 is discarded.
  assign commit_en = rdy_in && bus.rob_to_reg_commit && (bus.rob_to_reg_index != '0);
  assign rename_en = rdy_in && !clr_in && bus.dc_to_reg_rename && (bus.dc_to_reg_rd != '0);

  // Next state. The updates are applied in priority order:
  //   1. The flush clears all tags.
  //   2. The commit writes its value. It clears the tag only when that tag still names
  //      the retiring entry; a newer rename is left alone.
  //   3. The rename tag is applied last, so it overrides a same-register commit clear.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (rdy_in && clr_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end
    if (commit_en) begin
      val_d[bus.rob_to_reg_index] = bus.rob_to_reg_val;
      if (tag_q[bus.rob_to_reg_index] == bus.rob_to_reg_rob_index) begin
        tag_d[bus.rob_to_reg_index] = '0;
      end
    end
    if (rename_en) begin
      tag_d[bus.dc_to_reg_rd] = bus.dc_to_reg_rob_index;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  // Source 1 read. Reads see the pre-rename state.
  // A commit that retires this register's pending producer is bypassed straight
  // through, so the decoder never waits a cycle for a value that is already on the bus.
  always_comb begin
    bus.reg_to_dc_rs1_val = val_q[bus.dc_to_reg_rs1];
    bus.reg_to_dc_rs1_tag = tag_q[bus.dc_to_reg_rs1];
    if (bus.dc_to_reg_rs1 == '0) begin
      bus.reg_to_dc_rs1_val = '0;
      bus.reg_to_dc_rs1_tag = '0;
    end else if (commit_en && (bus.rob_to_reg_index == bus.dc_to_reg_rs1) &&
                 (tag_q[bus.dc_to_reg_rs1] == bus.rob_to_reg_rob_index)) begin
      bus.reg_to_dc_rs1_val = bus.rob_to_reg_val;
      bus.reg_to_dc_rs1_tag = '0;
    end
  end

  // Source 2 read. Uses the same rules as source 1.
  always_comb begin
    bus.reg_to_dc_rs2_val = val_q[bus.dc_to_reg_rs2];
    bus.reg_to_dc_rs2_tag = tag_q[bus.dc_to_reg_rs2];
    if (bus.dc_to_reg_rs2 == '0) begin
      bus.reg_to_dc_rs2_val = '0;
      bus.reg_to_dc_rs2_tag = '0;
    end else if (commit_en && (bus.rob_to_reg_index == bus.dc_to_reg_rs2) &&
                 (tag_q[bus.dc_to_reg_rs2] == bus.rob_to_reg_rob_index)) begin
      bus.reg_to_dc_rs2_val = bus.rob_to_reg_val;
      bus.reg_to_dc_rs2_tag = '0;
    end
  end

  // Keeps the index-width parameter tied to the interface it must match.
  if (IDX_W != $bits(bus.dc_to_reg_rd)) begin : g_idx_w_check
    $error("rename_reg_file: interface index width does not match REG_NUM");
  end
endmodule
